// File: rtl/i2c_slave_core.sv
// rtl/i2c_slave_core.sv - I2C target core: address match, byte-level user interface, SCL stretching
//
// Ports:
//   clk, reset           system clock (>= 8x SCL), synchronous active-high reset
//   scl_in, sda_in       bus pin levels
//   scl_out, sda_out     open-drain controls: 1 releases the line, 0 pulls it low
//   busy                 bus activity seen between START and STOP
//   addressed            this target has been selected and not yet deselected
//   rx_valid/rx_data     one-clk strobe with a received write byte
//   rx_first             qualifies rx_valid: first data byte after the address
//   tx_req               one-clk strobe asking the user for the next read byte
//   tx_valid/tx_data     user read byte, accepted only while a request is pending
//   tx_nack              one-clk strobe when the master NACKs a read byte
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_out,
  output logic       busy,
  output logic       addressed,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       tx_req,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_nack
);

  // Fewer than two synchronizer flops is never safe, so clamp the depth.
  localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] ST_WR_DATA  = 4'd3;
  localparam logic [3:0] ST_WR_ACK   = 4'd4;
  localparam logic [3:0] ST_RD_LOAD  = 4'd5;
  localparam logic [3:0] ST_RD_DATA  = 4'd6;
  localparam logic [3:0] ST_RD_ACK   = 4'd7;
  localparam logic [3:0] ST_IGNORE   = 4'd8;

  // ------------------------------------------------------------------
  // Input synchronizers plus one extra register for edge detection.
  // Both lines get identical latency so START/STOP ordering is kept.
  // ------------------------------------------------------------------
  logic [NSYNC-1:0] scl_sync;
  logic [NSYNC-1:0] sda_sync;
  logic             scl_d;
  logic             sda_d;
  logic             s_scl;
  logic             s_sda;

  always_ff @(posedge clk) begin
    if (reset) begin
      // An idle bus floats high; resetting to 1 avoids phantom edges.
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[NSYNC-2:0], scl_in};
      sda_sync <= {sda_sync[NSYNC-2:0], sda_in};
      scl_d    <= s_scl;
      sda_d    <= s_sda;
    end
  end

  assign s_scl = scl_sync[NSYNC-1];
  assign s_sda = sda_sync[NSYNC-1];

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  =  s_scl & ~scl_d;
  assign scl_fall  = ~s_scl &  scl_d;
  assign start_det =  s_scl & sda_d & ~s_sda;
  assign stop_det  =  s_scl & ~sda_d & s_sda;

  // ------------------------------------------------------------------
  // Protocol FSM
  // ------------------------------------------------------------------
  logic [3:0] state;
  logic [3:0] bit_cnt;     // bits shifted in/out of the current byte
  logic [7:0] shift_reg;   // receive shifter (address and write data)
  logic [7:0] tx_shift;    // remaining read bits, next one in [7]
  logic       rw_bit;      // R/W bit captured with the address
  logic       first_byte;  // next completed write byte is the first
  logic       tx_loaded;   // read byte accepted, release SCL next clk

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      shift_reg  <= 8'h00;
      tx_shift   <= 8'h00;
      rw_bit     <= 1'b0;
      first_byte <= 1'b0;
      tx_loaded  <= 1'b0;
      scl_out    <= 1'b1;
      sda_out    <= 1'b1;
      busy       <= 1'b0;
      addressed  <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      rx_first   <= 1'b0;
      tx_req     <= 1'b0;
      tx_nack    <= 1'b0;
    end else begin
      // Strobes default low; each is raised for exactly one clk below.
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
      tx_req   <= 1'b0;
      tx_nack  <= 1'b0;

      if (start_det) begin
        // START or repeated START: any partial byte is simply dropped.
        state     <= ST_ADDR;
        bit_cnt   <= 4'd0;
        tx_loaded <= 1'b0;
        sda_out   <= 1'b1;
        scl_out   <= 1'b1;
        busy      <= 1'b1;
        addressed <= 1'b0;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        bit_cnt   <= 4'd0;
        tx_loaded <= 1'b0;
        sda_out   <= 1'b1;
        scl_out   <= 1'b1;
        busy      <= 1'b0;
        addressed <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            // The SCL fall right after START arrives with bit_cnt=0 and
            // is ignored; only the fall after the 8th bit acts.
            if (scl_rise && bit_cnt != 4'd8) begin
              shift_reg <= {shift_reg[6:0], s_sda};
              bit_cnt   <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shift_reg[7:1] == SLAVE_ADDR) begin
                sda_out   <= 1'b0;
                addressed <= 1'b1;
                rw_bit    <= shift_reg[0];
                state     <= ST_ADDR_ACK;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              sda_out <= 1'b1;
              bit_cnt <= 4'd0;
              if (rw_bit) begin
                // Master reads: ask for data and hold SCL low meanwhile.
                state     <= ST_RD_LOAD;
                tx_req    <= 1'b1;
                scl_out   <= 1'b0;
                tx_loaded <= 1'b0;
              end else begin
                state      <= ST_WR_DATA;
                first_byte <= 1'b1;
              end
            end
          end

          ST_WR_DATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift_reg <= {shift_reg[6:0], s_sda};
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                rx_valid   <= 1'b1;
                rx_data    <= {shift_reg[6:0], s_sda};
                rx_first   <= first_byte;
                first_byte <= 1'b0;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_out <= 1'b0;
              state   <= ST_WR_ACK;
            end
          end

          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_out <= 1'b1;
              bit_cnt <= 4'd0;
              state   <= ST_WR_DATA;
            end
          end

          ST_RD_LOAD: begin
            // SCL stays low here, so driving the MSB now is legal; the
            // extra clk before release gives SDA setup time.
            if (tx_loaded) begin
              scl_out <= 1'b1;
              state   <= ST_RD_DATA;
            end else if (tx_valid) begin
              tx_shift  <= {tx_data[6:0], 1'b0};
              sda_out   <= tx_data[7];
              tx_loaded <= 1'b1;
              bit_cnt   <= 4'd1;
            end
          end

          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_out <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= ST_RD_ACK;
              end else begin
                sda_out  <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end

          ST_RD_ACK: begin
            // bit_cnt=1 marks an ACK already sampled in this slot.
            if (scl_rise && bit_cnt == 4'd0) begin
              if (s_sda) begin
                tx_nack   <= 1'b1;
                addressed <= 1'b0;
                state     <= ST_IGNORE;
              end else begin
                bit_cnt <= 4'd1;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt   <= 4'd0;
              state     <= ST_RD_LOAD;
              tx_req    <= 1'b1;
              scl_out   <= 1'b0;
              tx_loaded <= 1'b0;
            end
          end

          default: begin
            // IDLE, IGNORE: hands off the bus until START or STOP.
            sda_out <= 1'b1;
            scl_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_core.sv
// tb/tb_i2c_slave_core.sv - directed and randomized bench for i2c_slave_core
module tb_i2c_slave_core;

  localparam int Q = 5;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       master_scl = 1'b1;
  logic       master_sda = 1'b1;
  logic       scl_out, sda_out, busy, addressed;
  logic       rx_valid, rx_first, tx_req, tx_nack;
  logic [7:0] rx_data;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       scl_line, sda_line;

  assign scl_line = master_scl & scl_out;
  assign sda_line = master_sda & sda_out;

  i2c_slave_core #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_line), .sda_in(sda_line),
    .scl_out(scl_out), .sda_out(sda_out), .busy(busy), .addressed(addressed),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_first(rx_first),
    .tx_req(tx_req), .tx_valid(tx_valid), .tx_data(tx_data), .tx_nack(tx_nack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus monitor ----------------
  logic [8:0] rx_q[$];
  int tx_req_cnt = 0, tx_nack_cnt = 0, sda_low_cnt = 0, sda_chg_viol = 0;
  logic prev_sda = 1'b1, prev_scl = 1'b1;

  always @(negedge clk) begin
    if (reset) begin
      prev_sda = 1'b1;
      prev_scl = 1'b1;
    end else begin
      if (rx_valid) rx_q.push_back({rx_first, rx_data});
      if (tx_req) tx_req_cnt++;
      if (tx_nack) tx_nack_cnt++;
      if (!sda_out) sda_low_cnt++;
      if (sda_out !== prev_sda && scl_line && prev_scl) sda_chg_viol++;
      prev_sda = sda_out;
      prev_scl = scl_line;
    end
  end

  // ---------------- user transmit side ----------------
  logic [7:0] tx_q[$];
  int dly_q[$];
  int hold_viol = 0;

  initial begin
    logic [7:0] d;
    int w;
    forever begin
      @(negedge clk);
      if (tx_req && !reset) begin
        d = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
        w = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
        for (int i = 0; i < w; i++) begin
          @(negedge clk);
          if (scl_out) hold_viol++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    end
  end

  // ---------------- master bit-level tasks ----------------
  int max_stretch = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scl_release();
    int n;
    n = 0;
    master_scl = 1'b1;
    tick(1);
    while (scl_line !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    if (n > max_stretch) max_stretch = n;
    if (scl_line !== 1'b1) check("scl_release_timeout", scl_line, 1'b1);
  endtask

  task automatic i2c_start();
    master_sda = 1'b1; tick(Q);
    scl_release();     tick(Q);
    master_sda = 1'b0; tick(Q);
    master_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    master_sda = 1'b0; tick(Q);
    scl_release();     tick(Q);
    master_sda = 1'b1; tick(2*Q);
  endtask

  task automatic write_bit(input logic b);
    master_sda = b;    tick(Q);
    scl_release();     tick(2*Q);
    master_scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    master_sda = 1'b1; tick(Q);
    scl_release();     tick(Q);
    b = sda_line;      tick(Q);
    master_scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(ack);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic       ack;
    logic [7:0] d0, d1;
    logic [8:0] e;
    logic [6:0] addr;
    logic [7:0] bytes[3];
    int         n, kind;

    // Reset state
    tick(3);
    check("rst_scl_out", scl_out, 1'b1);
    check("rst_sda_out", sda_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_addressed", addressed, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_first", rx_first, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_tx_nack", tx_nack, 1'b0);
    reset = 1'b0;
    tick(5);

    // Write 0x12, 0x34 to 0x50
    rx_q.delete();
    i2c_start();
    check("wr_busy", busy, 1'b1);
    write_byte(8'hA0, ack); check("wr_addr_ack", ack, 1'b0);
    check("wr_addressed", addressed, 1'b1);
    write_byte(8'h12, ack); check("wr_ack0", ack, 1'b0);
    write_byte(8'h34, ack); check("wr_ack1", ack, 1'b0);
    i2c_stop();
    check("wr_busy_after_stop", busy, 1'b0);
    check("wr_addressed_after_stop", addressed, 1'b0);
    check("wr_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      e = rx_q[0]; check("wr_rx0", e, {1'b1, 8'h12});
      e = rx_q[1]; check("wr_rx1", e, {1'b0, 8'h34});
    end

    // Address mismatch
    rx_q.delete();
    sda_low_cnt = 0;
    i2c_start();
    write_byte(8'hA2, ack); check("mis_addr_ack", ack, 1'b1);
    check("mis_addressed", addressed, 1'b0);
    write_byte(8'h55, ack); check("mis_data_ack", ack, 1'b1);
    i2c_stop();
    check("mis_sda_low", sda_low_cnt, 0);
    check("mis_rx_count", rx_q.size(), 0);

    // Read with a 20-clk user delay
    tx_q.push_back(8'hC3); dly_q.push_back(20);
    hold_viol = 0; tx_req_cnt = 0; tx_nack_cnt = 0; max_stretch = 0;
    i2c_start();
    write_byte(8'hA1, ack); check("rd_addr_ack", ack, 1'b0);
    read_byte(d0, 1'b1);
    check("rd_data_c3", d0, 8'hC3);
    i2c_stop();
    check("rd_hold_low", hold_viol, 0);
    check("rd_stretch_seen", (max_stretch >= 8), 1'b1);
    check("rd_tx_req_cnt", tx_req_cnt, 1);
    check("rd_tx_nack_cnt", tx_nack_cnt, 1);

    // Two-byte read: ACK then NACK; second request answered same cycle
    tx_q.push_back(8'h5A); dly_q.push_back($urandom_range(1, 6));
    tx_q.push_back(8'hA5); dly_q.push_back(0);
    tx_req_cnt = 0; tx_nack_cnt = 0;
    i2c_start();
    write_byte(8'hA1, ack); check("rd2_addr_ack", ack, 1'b0);
    read_byte(d0, 1'b0);
    read_byte(d1, 1'b1);
    check("rd2_sda_released", sda_out, 1'b1);
    check("rd2_addressed_after_nack", addressed, 1'b0);
    i2c_stop();
    check("rd2_byte0", d0, 8'h5A);
    check("rd2_byte1", d1, 8'hA5);
    check("rd2_tx_req_cnt", tx_req_cnt, 2);
    check("rd2_tx_nack_cnt", tx_nack_cnt, 1);

    // Write then repeated START into a read
    rx_q.delete(); tx_req_cnt = 0; tx_nack_cnt = 0;
    tx_q.push_back(8'h99); dly_q.push_back(3);
    i2c_start();
    write_byte(8'hA0, ack); check("rs_addr_ack", ack, 1'b0);
    write_byte(8'h07, ack); check("rs_data_ack", ack, 1'b0);
    i2c_start();
    check("rs_busy", busy, 1'b1);
    check("rs_addressed", addressed, 1'b0);
    check("rs_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) begin
      e = rx_q[0]; check("rs_rx0", e, {1'b1, 8'h07});
    end
    check("rs_no_tx_req_yet", tx_req_cnt, 0);
    write_byte(8'hA1, ack); check("rs_rd_addr_ack", ack, 1'b0);
    read_byte(d0, 1'b1);
    i2c_stop();
    check("rs_rd_data", d0, 8'h99);
    check("rs_tx_req_cnt", tx_req_cnt, 1);
    check("rs_rx_count_end", rx_q.size(), 1);

    // Reset while SCL is stretched
    tx_req_cnt = 0;
    tx_q.push_back(8'h00); dly_q.push_back(60);
    i2c_start();
    write_byte(8'hA1, ack); check("rst_mid_addr_ack", ack, 1'b0);
    tick(8);
    check("rst_mid_stretch", scl_out, 1'b0);
    check("rst_mid_tx_req", tx_req_cnt, 1);
    master_scl = 1'b1;
    tick(5);
    check("rst_mid_line_low", scl_line, 1'b0);
    reset = 1'b1;
    tick(1);
    check("rst_mid_scl_out", scl_out, 1'b1);
    check("rst_mid_sda_out", sda_out, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    reset = 1'b0;
    tick(80);
    check("rst_mid_stray_tx_sda", sda_out, 1'b1);
    check("rst_mid_stray_tx_scl", scl_out, 1'b1);
    rx_q.delete();
    i2c_start();
    write_byte(8'hA0, ack); check("rst_after_addr_ack", ack, 1'b0);
    write_byte(8'h3C, ack); check("rst_after_data_ack", ack, 1'b0);
    i2c_stop();
    check("rst_after_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) begin
      e = rx_q[0]; check("rst_after_rx0", e, {1'b1, 8'h3C});
    end

    // STOP after 4 bits of a write byte
    rx_q.delete();
    i2c_start();
    write_byte(8'hA0, ack); check("part_addr_ack", ack, 1'b0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    check("part_rx_count", rx_q.size(), 0);
    check("part_busy", busy, 1'b0);
    check("part_addressed", addressed, 1'b0);
    check("part_sda_out", sda_out, 1'b1);
    i2c_start();
    write_byte(8'hA0, ack); check("part_next_addr_ack", ack, 1'b0);
    write_byte(8'h5C, ack); check("part_next_ack", ack, 1'b0);
    i2c_stop();
    check("part_next_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) begin
      e = rx_q[0]; check("part_next_rx0", e, {1'b1, 8'h5C});
    end

    // Randomized transactions against a transaction-level model
    for (int t = 0; t < 6; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom_range(0, 255));
      rx_q.delete(); tx_req_cnt = 0; tx_nack_cnt = 0;
      if (kind == 2) begin
        for (int i = 0; i < n; i++) begin
          tx_q.push_back(bytes[i]);
          dly_q.push_back($urandom_range(0, 8));
        end
        i2c_start();
        write_byte(8'hA1, ack); check("rnd_rd_addr_ack", ack, 1'b0);
        for (int i = 0; i < n; i++) begin
          read_byte(d0, (i == n - 1));
          check("rnd_rd_data", d0, bytes[i]);
        end
        i2c_stop();
        check("rnd_rd_tx_req_cnt", tx_req_cnt, n);
        check("rnd_rd_tx_nack_cnt", tx_nack_cnt, 1);
      end else begin
        addr = (kind == 0) ? 7'h50 : 7'(7'h50 + 7'($urandom_range(1, 127)));
        i2c_start();
        write_byte({addr, 1'b0}, ack);
        check("rnd_wr_addr_ack", ack, (addr == 7'h50) ? 1'b0 : 1'b1);
        for (int i = 0; i < n; i++) begin
          write_byte(bytes[i], ack);
          check("rnd_wr_data_ack", ack, (addr == 7'h50) ? 1'b0 : 1'b1);
        end
        i2c_stop();
        check("rnd_wr_rx_count", rx_q.size(), (addr == 7'h50) ? n : 0);
        if (addr == 7'h50 && rx_q.size() == n) begin
          for (int i = 0; i < n; i++) begin
            e = rx_q[i];
            check("rnd_wr_rx", e, {(i == 0), bytes[i]});
          end
        end
      end
    end

    check("sda_changed_while_scl_high", sda_chg_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_core.md
Name: i2c_slave_core

Overview:
Synthesizable I2C target (slave) that answers the bus driven by the team's I2C master agent. Pins are open-drain style: an output of 1 releases the line and 0 pulls it low. The block oversamples SCL/SDA on the system clock, detects START/STOP, and matches a 7-bit address. It presents received bytes and requests transmit bytes on a simple byte-level user interface, stretching SCL while transmit data is pending.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this target acknowledges.
SYNC_STAGES, 2, flops in each SCL/SDA input synchronizer (min 2).

Ports:
clk        in   1  system clock, at least 8x SCL rate.
reset      in   1  synchronous, active-high reset.
scl_in     in   1  SCL pin level.
sda_in     in   1  SDA pin level.
scl_out    out  1  1 = release SCL, 0 = stretch (hold low).
sda_out    out  1  1 = release SDA, 0 = drive low.
busy       out  1  high from START to STOP.
addressed  out  1  high while this target is selected (address ACKed) until STOP, repeated START or master NACK.
rx_valid   out  1  one-clk pulse; rx_data holds a received write byte.
rx_data    out  8  last received data byte, MSB first on the wire.
rx_first   out  1  qualifies rx_valid; high for the first data byte after the address.
tx_req     out  1  one-clk pulse; the core needs the next read byte.
tx_valid   in   1  user supplies tx_data; sampled only while a request is pending.
tx_data    in   8  read byte.
tx_nack    out  1  one-clk pulse when the master NACKs a read byte.

Behaviour:
- Reset value of every output: scl_out=1, sda_out=1, busy=0, addressed=0, rx_valid=0, rx_data=0, rx_first=0, tx_req=0, tx_nack=0. The FSM goes to IDLE.
- Synchronization: SCL and SDA pass through SYNC_STAGES flops, then one register for edge detection. All decisions use the synchronized values (s_scl, s_sda).
- Bus events:
  - START: s_sda falls while s_scl=1.
  - STOP: s_sda rises while s_scl=1.
  - Both are checked every cycle and override any state.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, IGNORE.
- START or repeated START, from any state:
  - go to ADDR, bit counter=0, release SDA and SCL.
  - busy=1; addressed=0.
- STOP, from any state:
  - go to IDLE, release both lines.
  - busy=0; addressed=0.
- ADDR:
  - shift s_sda on each s_scl rising edge; 8 bits total (7 address bits + R/W).
  - Address match: on the s_scl falling edge after bit 8, sda_out=0, addressed=1, go to ADDR_ACK.
  - Mismatch (including general call 7'h00): go to IGNORE with SDA released.
- ADDR_ACK: on the next s_scl falling edge, release SDA.
  - R/W=0: go to WR_DATA.
  - R/W=1: go to RD_LOAD.
- WR_DATA:
  - shift 8 bits on s_scl rising edges.
  - On the rising edge that samples bit 0, in the following clk: rx_valid=1, rx_data updated, rx_first=1 only for the first byte of the transfer.
  - On the next s_scl falling edge, sda_out=0 (every write byte is ACKed) and go to WR_ACK.
- WR_ACK: on the next s_scl falling edge, release SDA and return to WR_DATA.
- RD_LOAD:
  - on entry, tx_req pulses once and scl_out=0 is held.
  - when tx_valid=1, in that cycle or later, latch tx_data and drive its MSB on sda_out; one clk later release SCL and go to RD_DATA.
  - tx_valid high in the same cycle as tx_req is accepted.
  - tx_valid outside RD_LOAD is ignored.
- RD_DATA:
  - present the next bit on each s_scl falling edge.
  - after the 8th bit's falling edge, release SDA and go to RD_ACK.
- RD_ACK: sample s_sda on the s_scl rising edge.
  - 0 (ACK): on the falling edge go to RD_LOAD.
  - 1 (NACK): pulse tx_nack, addressed=0, go to IGNORE.
- IGNORE: both lines released; wait for START or STOP.
- STOP or START in mid-byte: the partial byte is discarded and no rx_valid is generated.
- Reset in mid-transfer: outputs take their reset values on the next clk edge, so a stretched SCL or a held ACK is released immediately.
- Never drive sda_out=0 except in ACK slots and read data bits. Never change sda_out while s_scl=1.

Test Plan:
- START, 0xA0 (0x50 write), 0x12, 0x34, STOP:
  - address ACK, plus ACK after each byte;
  - rx_valid twice with rx_data 0x12 (rx_first=1) then 0x34 (rx_first=0);
  - busy falls after STOP.
- START, 0xA2 (0x51), 0x55, STOP:
  - SDA never driven low, no rx_valid, addressed stays 0.
- START, 0xA1 read; user delays tx_valid 20 clk with tx_data=0xC3:
  - SCL held low for the whole wait;
  - bits 1,1,0,0,0,0,1,1 appear on SDA.
- Read of two bytes 0x5A then 0xA5, master ACKs the first and NACKs the second:
  - tx_req pulses twice, tx_nack pulses once;
  - SDA released before STOP.
- Write 0xA0, 0x07, then repeated START, 0xA1, read 0x99, NACK, STOP:
  - rx_valid once (0x07), then tx_req once;
  - state is ADDR after the repeated START.
- Two further cases:
  - Assert reset while SCL is stretched in RD_LOAD: scl_out=1 and sda_out=1 on the next clk; the next START is handled normally.
  - STOP after 4 bits of a write byte: no rx_valid, core back in IDLE.
